// File: rtl/pipelined_adder_acc.sv
// pipelined_adder_acc: add/sub/accumulate unit with STAGES-deep stalled pipeline; optional saturation via PIPELINED_ADDER_ACC_SAT_EN
module pipelined_adder_acc #(
    parameter int WIDTH  = 40,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry
);
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

    logic             advance, fire, cy;
    logic [WIDTH-1:0] acc, base, res;
    logic [WIDTH:0]   s_add, s_sub, s_acc;
    logic             v  [STAGES];
    logic [WIDTH-1:0] cr [STAGES];
    logic             cq [STAGES];

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign fire      = in_valid && advance;
    assign out_valid = v[STAGES-1];
    assign c         = cr[STAGES-1];
    assign carry     = cq[STAGES-1];

    // stage-1 arithmetic on the presented beat, with acc_clr applied before the op
    always_comb begin
        base  = acc_clr ? '0 : acc;
        s_add = {1'b0, a} + {1'b0, b};
        s_sub = {1'b0, a} - {1'b0, b};
        s_acc = {1'b0, base} + {1'b0, a};
        cy    = in_mode == ADD ? s_add[WIDTH] : in_mode == SUB ? s_sub[WIDTH] : in_mode == ACC ? s_acc[WIDTH] : 1'b0;
        res   = in_mode == ADD ? s_add[WIDTH-1:0] : in_mode == SUB ? s_sub[WIDTH-1:0] : in_mode == ACC ? s_acc[WIDTH-1:0] : a;
`ifdef PIPELINED_ADDER_ACC_SAT_EN
        if (cy) res = in_mode == SUB ? '0 : '1;
`endif
    end

    // accumulator updates only on accepted beats; ADD/SUB keep it unless cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc <= '0;
        else if (fire) acc <= (in_mode == ACC || in_mode == LOAD) ? res : base;
    end

    // result pipeline, advancing as a whole only when the output slot is free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                v[i]  <= 1'b0;
                cr[i] <= '0;
                cq[i] <= 1'b0;
            end
        end else if (advance) begin
            v[0]  <= fire;
            cr[0] <= res;
            cq[0] <= cy;
            for (int i = 1; i < STAGES; i++) begin
                v[i]  <= v[i-1];
                cr[i] <= cr[i-1];
                cq[i] <= cq[i-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder_acc.sv
// tb_pipelined_adder_acc: scoreboard bench for pipelined_adder_acc at WIDTH=8, STAGES=2
module tb_pipelined_adder_acc;
    logic       clk = 0, rst = 0, in_valid = 0, in_ready, acc_clr = 0;
    logic       out_valid, out_ready = 1, carry;
    logic [1:0] in_mode = 0;
    logic [7:0] a = 0, b = 0, c;
    logic [8:0] q[$];
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] hc;
    logic       hy;

    pipelined_adder_acc #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] ta, input logic [7:0] tb_, input logic clr,
                        input logic [7:0] ec, input logic ecy);
        int k = 0;
        in_valid = 1; in_mode = m; a = ta; b = tb_; acc_clr = clr;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 50);
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        else q.push_back({ec, ecy});
        @(posedge clk); #1;
        in_valid = 0; acc_clr = 0;
    endtask

    // monitor: every output transfer must match the oldest expected result
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_output", 1, 0);
            else chk("result", {c, carry}, q.pop_front());
        end
    end

    initial begin
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_carry", carry, 0);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        send(2'b00, 8'h7F, 8'h01, 0, 8'h80, 0);
        @(negedge clk); chk("lat_1cyc", out_valid, 0);
        @(negedge clk); chk("lat_2cyc", out_valid, 1);
        @(posedge clk); #1;
`ifdef PIPELINED_ADDER_ACC_SAT_EN
        send(2'b00, 8'hFF, 8'h02, 0, 8'hFF, 1);
        send(2'b01, 8'h03, 8'h05, 0, 8'h00, 1);
`else
        send(2'b00, 8'hFF, 8'h02, 0, 8'h01, 1);
        send(2'b01, 8'h03, 8'h05, 0, 8'hFE, 1);
`endif
        send(2'b11, 8'h10, 8'h00, 0, 8'h10, 0);
        send(2'b10, 8'h05, 8'h00, 0, 8'h15, 0);
        send(2'b10, 8'h05, 8'h00, 0, 8'h1A, 0);
`ifdef PIPELINED_ADDER_ACC_SAT_EN
        send(2'b10, 8'hF0, 8'h00, 0, 8'hFF, 1);
`else
        send(2'b10, 8'hF0, 8'h00, 0, 8'h0A, 1);
`endif
        repeat (3) @(posedge clk); #1;

        fork
            begin
                send(2'b00, 8'h10, 8'h01, 0, 8'h11, 0);
                send(2'b00, 8'h20, 8'h02, 0, 8'h22, 0);
                send(2'b00, 8'h30, 8'h03, 0, 8'h33, 0);
                send(2'b00, 8'h40, 8'h04, 0, 8'h44, 0);
                send(2'b00, 8'h50, 8'h05, 0, 8'h55, 0);
                send(2'b00, 8'h60, 8'h06, 0, 8'h66, 0);
            end
            begin
                repeat (3) @(posedge clk); #1;
                out_ready = 0;
                hc = c; hy = carry;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_c", c, hc);
                    chk("stall_carry", carry, hy);
                end
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        repeat (4) @(posedge clk); #1;

        send(2'b11, 8'h40, 8'h00, 0, 8'h40, 0);
        send(2'b10, 8'h22, 8'h00, 1, 8'h22, 0);
        acc_clr = 1;
        @(posedge clk); #1;
        acc_clr = 0;
        send(2'b10, 8'h01, 8'h00, 0, 8'h23, 0);
        repeat (4) @(posedge clk); #1;

        send(2'b00, 8'h01, 8'h01, 0, 8'h02, 0);
        send(2'b00, 8'h02, 8'h02, 0, 8'h04, 0);
        chk("pre_rst_valid", out_valid, 1);
        #1 rst = 0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_c", c, 0);
        chk("async_rst_carry", carry, 0);
        q.delete();
        @(posedge clk); #1;
        rst = 1;
        send(2'b10, 8'h07, 8'h00, 0, 8'h07, 0);
        send(2'b00, 8'h01, 8'h01, 1, 8'h02, 0);
        send(2'b10, 8'h03, 8'h00, 0, 8'h03, 0);

        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
